// File: rtl/alu_pkg.sv
// Shared op-code constants, controller state encoding and op-class helper
// for the ALU / multiply-divide unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

  function automatic logic is_iterative(input logic [4:0] ctl);
    return (ctl >= OP_MUL) && (ctl <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between a producer and the ALU/MDU.
interface alu_mdu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      ctl;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            ifZero;

  modport master (output in_valid, ctl, src1, src2, out_ready,
                  input  in_ready, out_valid, result, ifZero);
  modport slave  (input  in_valid, ctl, src1, src2, out_ready,
                  output in_ready, out_valid, result, ifZero);
endinterface

// File: rtl/alu_iter_core.sv
// Radix-2 shift-add multiplier / restoring divider on operand magnitudes;
// res_o applies sign correction and high/low selection for the FIX cycle.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            last_o,
  output logic [XLEN-1:0] res_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] hi_q, lo_q, m_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic            an_q, bn_q;

  logic            a_sgn, b_sgn, a_neg, b_neg, mul_in, mul_op;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   sum, trial;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] q_s, r_s;

  assign a_sgn  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign b_sgn  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg  = a_sgn & a_i[XLEN-1];
  assign b_neg  = b_sgn & b_i[XLEN-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign mul_in = op_i <= OP_MULHU;
  assign mul_op = op_q <= OP_MULHU;

  // Multiply: hi:lo holds partial product and shifting multiplier.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign trial  = {hi_q, lo_q[XLEN-1]} - {1'b0, m_q};
  assign last_o = cnt_q == CW'(XLEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      an_q  <= 1'b0;
      bn_q  <= 1'b0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= mul_in ? b_mag : a_mag;
      m_q   <= mul_in ? a_mag : b_mag;
      cnt_q <= '0;
      op_q  <= op_i;
      an_q  <= a_neg;
      bn_q  <= b_neg;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (mul_op) begin
        hi_q <= sum[XLEN:1];
        lo_q <= {sum[0], lo_q[XLEN-1:1]};
      end else if (!trial[XLEN]) begin
        hi_q <= trial[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_q <= {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign prod_s = (an_q ^ bn_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign q_s    = (an_q ^ bn_q) ? -lo_q : lo_q;
  assign r_s    = an_q ? -hi_q : hi_q;

  always_comb begin
    res_o = r_s;
    case (op_q)
      OP_MUL:                       res_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_o = q_s;
      default:                      res_o = r_s;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Single-issue ALU with iterative multiply/divide; one request in flight,
// result held in DONE until the consumer takes it.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave bus
);
  state_e          state_q;
  logic [XLEN-1:0] result_q, comb_res, core_res;
  logic            zero_q, core_last;
  logic [SHW-1:0]  sh;
  logic            div_zero, div_ovf, bypass, go_iter, is_divrem, is_sdiv;

  assign sh        = bus.src2[SHW-1:0];
  assign div_zero  = bus.src2 == '0;
  assign div_ovf   = (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src2 == '1);
  assign is_divrem = (bus.ctl == OP_DIV) || (bus.ctl == OP_DIVU) ||
                     (bus.ctl == OP_REM) || (bus.ctl == OP_REMU);
  assign is_sdiv   = (bus.ctl == OP_DIV) || (bus.ctl == OP_REM);
  // Divide-by-zero and signed overflow have closed-form answers; skip the loop.
  assign bypass    = (is_divrem && div_zero) || (is_sdiv && div_ovf);
  assign go_iter   = is_iterative(bus.ctl) && !bypass;

  always_comb begin
    comb_res = '1;
    case (bus.ctl)
      OP_ADD:          comb_res = bus.src1 + bus.src2;
      OP_SUB:          comb_res = bus.src1 - bus.src2;
      OP_SLL:          comb_res = bus.src1 << sh;
      OP_SLT:          comb_res = {{(XLEN-1){1'b0}}, $signed(bus.src1) < $signed(bus.src2)};
      OP_SLTU:         comb_res = {{(XLEN-1){1'b0}}, bus.src1 < bus.src2};
      OP_XOR:          comb_res = bus.src1 ^ bus.src2;
      OP_SRL:          comb_res = bus.src1 >> sh;
      OP_SRA:          comb_res = $unsigned($signed(bus.src1) >>> sh);
      OP_OR:           comb_res = bus.src1 | bus.src2;
      OP_AND:          comb_res = bus.src1 & bus.src2;
      OP_DIV, OP_DIVU: comb_res = div_zero ? '1 : bus.src1;
      OP_REM, OP_REMU: comb_res = div_zero ? bus.src1 : '0;
      default:         comb_res = '1;
    endcase
  end

  alu_iter_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (state_q == S_IDLE && bus.in_valid && go_iter),
    .step_i  (state_q == S_BUSY),
    .op_i    (bus.ctl),
    .a_i     (bus.src1),
    .b_i     (bus.src2),
    .last_o  (core_last),
    .res_o   (core_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          if (go_iter) state_q <= S_BUSY;
          else begin
            state_q  <= S_DONE;
            result_q <= comb_res;
            zero_q   <= comb_res == '0;
          end
        end
        S_BUSY: if (core_last) state_q <= S_FIX;
        S_FIX: begin
          state_q  <= S_DONE;
          result_q <= core_res;
          zero_q   <= core_res == '0;
        end
        S_DONE:  if (bus.out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.result    = result_q;
  assign bus.ifZero    = zero_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: arithmetic reference model plus per-cycle handshake
// tracking, directed corner cases and randomized traffic.
module tb_alu_mdu;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_mdu_if #(.XLEN(XLEN)) bus();
  alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = int'(b[4:0]);
    case (c)
      0:  p = ua + ub;
      1:  p = ua - ub;
      2:  p = ua << sh;
      3:  p = (sa < sb) ? 1 : 0;
      4:  p = (ua < ub) ? 1 : 0;
      5:  p = ua ^ ub;
      6:  p = ua >> sh;
      7:  p = sa >>> sh;
      8:  p = ua | ub;
      9:  p = ua & ub;
      10: p = sa * sb;
      11: p = (sa * sb) >>> 32;
      12: p = (sa * ub) >>> 32;
      13: p = longint'(64'(ua * ub) >> 32);
      14: p = (b == 0) ? -1 : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? ua : sa / sb;
      15: p = (b == 0) ? -1 : ua / ub;
      16: p = (b == 0) ? ua : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 0 : sa % sb;
      17: p = (b == 0) ? ua : ua % ub;
      default: p = -1;
    endcase
    return p[31:0];
  endfunction

  // Edges from acceptance (inclusive) until out_valid is visible.
  function automatic int model_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c < 10 || c > 17) return 1;
    if (c >= 14 && b == 0) return 1;
    if ((c == 14 || c == 16) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 2;
  endfunction

  task automatic checkw(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Cycle-level expectation: what the handshake and result must look like.
  typedef enum {M_IDLE, M_WAIT, M_DONE} mmode_e;
  mmode_e      mmode = M_IDLE;
  int          mcnt = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      mmode = M_IDLE;
      m_res = '0;
    end else begin
      case (mmode)
        M_IDLE: if (bus.in_valid) begin
          m_pend = model(bus.ctl, bus.src1, bus.src2);
          mcnt   = model_lat(bus.ctl, bus.src1, bus.src2) - 1;
          if (mcnt == 0) begin mmode = M_DONE; m_res = m_pend; end
          else mmode = M_WAIT;
        end
        M_WAIT: begin
          mcnt--;
          if (mcnt == 0) begin mmode = M_DONE; m_res = m_pend; end
        end
        M_DONE: if (bus.out_ready) mmode = M_IDLE;
        default: mmode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    checkw("in_ready", 32'(bus.in_ready), 32'(mmode == M_IDLE));
    checkw("out_valid", 32'(bus.out_valid), 32'(mmode == M_DONE));
    if (mmode == M_DONE) begin
      checkw("result", bus.result, m_res);
      checkw("ifZero", 32'(bus.ifZero), 32'(m_res == 0));
    end
  end

  task automatic scramble();
    bus.in_valid = 1'($urandom);
    bus.ctl      = 5'($urandom);
    bus.src1     = $urandom;
    bus.src2     = $urandom;
  endtask

  // Issue one request to an idle DUT, check latency and result, stall, release.
  task automatic send(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                      input int stall, input logic [31:0] exp, input int lat, input string nm);
    int n;
    bus.in_valid  = 1'b1;
    bus.ctl       = c;
    bus.src1      = a;
    bus.src2      = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    n = 1;
    scramble();
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      scramble();
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", nm, n, lat);
    end
    checkw({nm, " result"}, bus.result, exp);
    repeat (stall) begin
      @(posedge clk); #1;
      scramble();
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    logic [4:0]  c;
    logic [31:0] a, b;
    bus.in_valid  = 1'b0;
    bus.ctl       = '0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkw("reset result", bus.result, 32'h0);
    checkw("reset ifZero", 32'(bus.ifZero), 32'h0);
    checkw("reset in_ready", 32'(bus.in_ready), 32'h1);

    send(5'd0,  32'h7FFFFFFF, 32'h1,        0, 32'h80000000, 1,  "add_ovf");
    send(5'd1,  32'h5,        32'h5,        0, 32'h0,        1,  "sub_zero");
    send(5'd7,  32'h80000000, 32'h24,       0, 32'hF8000000, 1,  "sra");
    send(5'd4,  32'h1,        32'hFFFFFFFF, 0, 32'h1,        1,  "sltu");
    send(5'd3,  32'h1,        32'hFFFFFFFF, 0, 32'h0,        1,  "slt");
    send(5'd2,  32'h1,        32'h21,       0, 32'h2,        1,  "sll");
    send(5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1,        34, "mul");
    send(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0,        34, "mulh");
    send(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 34, "mulhsu");
    send(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 34, "mulhu");
    send(5'd14, 32'hFFFFFFF9, 32'h2,        0, 32'hFFFFFFFD, 34, "div");
    send(5'd16, 32'hFFFFFFF9, 32'h2,        0, 32'hFFFFFFFF, 34, "rem");
    send(5'd16, 32'h7,        32'hFFFFFFFE, 0, 32'h1,        34, "rem_pos");
    send(5'd15, 32'h7,        32'h0,        0, 32'hFFFFFFFF, 1,  "divu_zero");
    send(5'd17, 32'h7,        32'h0,        0, 32'h7,        1,  "remu_zero");
    send(5'd14, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1,  "div_ovf");
    send(5'd16, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0,        1,  "rem_ovf");
    send(5'd20, 32'h1234,     32'h5678,     0, 32'hFFFFFFFF, 1,  "undef_op");
    send(5'd0,  32'h3,        32'h4,        5, 32'h7,        1,  "stall");

    // Abort a DIVU mid-iteration.
    bus.in_valid = 1'b1; bus.ctl = 5'd15; bus.src1 = 32'd100; bus.src2 = 32'd7;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checkw("abort out_valid", 32'(bus.out_valid), 32'h0);
    checkw("abort result", bus.result, 32'h0);
    checkw("abort in_ready", 32'(bus.in_ready), 32'h1);
    send(5'd0, 32'h10, 32'h20, 0, 32'h30, 1, "post_abort_add");

    for (int i = 0; i < 200; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      send(c, a, b, $urandom_range(0, 3), model(c, a, b), model_lat(c, a, b), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(XLEN), number of shift-amount bits taken from src2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present; in_ready  output  1  block can accept.
REQ-006 ctl  input  5  operation code; src1, src2  input  XLEN  operands.
REQ-007 out_valid  output  1  result present; out_ready  input  1  consumer accepts.
REQ-008 result  output  XLEN  registered result; ifZero  output  1  high when result==0, registered with result.

Function
REQ-009 Op codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
REQ-010 Codes 18..31 SHALL produce result = all ones, latency 1.
REQ-011 Shifts SHALL use src2[SHW-1:0] only; SLT/SLTU results SHALL be 1 or 0 zero-extended.
REQ-012 Transfer in SHALL occur on an edge where in_valid && in_ready; transfer out on an edge where out_valid && out_ready.
REQ-013 FSM states IDLE, BUSY, FIX, DONE; in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-014 Ops 0..9 and 18..31 accepted at edge N: IDLE->DONE, out_valid high from cycle N+1.
REQ-015 Ops 10..17 accepted at edge N: IDLE->BUSY for exactly XLEN cycles (radix-2 iterative), then FIX one cycle (sign correction, high/low select), then DONE; out_valid high from cycle N+XLEN+2.
REQ-016 MUL SHALL return low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU high XLEN bits with s*s, s*u, u*u operand signedness.
REQ-017 Divide by zero SHALL bypass BUSY (latency 1): DIV/DIVU quotient all ones, REM/REMU remainder = src1.
REQ-018 Signed overflow (src1 = most-negative, src2 = -1) SHALL bypass BUSY (latency 1): DIV quotient = src1, REM remainder 0.
REQ-019 Signed DIV SHALL truncate toward zero; REM sign SHALL equal the dividend sign.
REQ-020 In DONE, result and ifZero SHALL hold stable until out_ready; DONE && out_ready -> IDLE, in_ready high the following cycle.
REQ-021 Operands and ctl SHALL be captured at acceptance; input changes after acceptance SHALL NOT affect the result.
REQ-022 out_valid && out_ready with a simultaneous in_valid SHALL NOT accept the new request that cycle (in_ready low in DONE).

Reset
REQ-023 rst high at an edge SHALL force IDLE, result = 0, ifZero = 0, out_valid = 0, iteration counter = 0, in any state.
REQ-024 rst mid-BUSY/FIX/DONE SHALL abort the operation with no result delivered; in_ready SHALL be high the cycle after rst deasserts.

Structure
REQ-025 Package alu_pkg SHALL hold the 5-bit op-code constants, the FSM state enum and an is_iterative(ctl) helper.
REQ-026 The iterative shift-add/shift-subtract datapath (counter, partial product/remainder registers) SHALL be one sub-module, alu_iter_core; combinational ops stay in alu_mdu.

Verification (XLEN=32)
REQ-027 ADD 0x7FFFFFFF+1, out_ready high -> out_valid at N+1, result 0x80000000, ifZero 0; SUB 5-5 -> result 0, ifZero 1.
REQ-028 SRA 0x80000000 by src2=0x00000024 -> shift 4, result 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same -> 0.
REQ-029 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001; out_valid at exactly N+34.
REQ-030 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at N+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-031 out_ready low for 5 cycles after out_valid -> result, ifZero, out_valid stable, in_ready low throughout; accept on release.
REQ-032 rst asserted at cycle N+10 of a DIVU -> next cycle out_valid 0, result 0, in_ready 1; following ADD completes normally.
